// File: rtl/mantissa_mul_seq_pkg.sv
// Shared FPU multiply-path constants and the sequential multiplier state encoding.
package mantissa_mul_seq_pkg;

    localparam int MANTISSA_LENGTH = 24;
    localparam int PRODUCT_LENGTH  = 2 * MANTISSA_LENGTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mantissa_mul_seq_step.sv
// One shift-add partial-product cell: conditional add of the multiplicand into the
// upper accumulator, then a 1-bit right shift that keeps the adder carry.
module single_mul_step
    import mantissa_mul_seq_pkg::*;
#(
    parameter int MANTISSA_LENGTH = mantissa_mul_seq_pkg::MANTISSA_LENGTH
) (
    input  logic [MANTISSA_LENGTH-1:0] acc_hi,
    input  logic [MANTISSA_LENGTH-1:0] mcand,
    input  logic                       mplier_lsb,
    output logic [MANTISSA_LENGTH-1:0] next_acc_hi,
    output logic                       shift_bit
);

    logic [MANTISSA_LENGTH:0] sum;

    assign sum = {1'b0, acc_hi} + {1'b0, mcand & {MANTISSA_LENGTH{mplier_lsb}}};

    // The carry lands in the MSB of the shifted accumulator; the LSB drops into the low half.
    assign next_acc_hi = sum[MANTISSA_LENGTH:1];
    assign shift_bit   = sum[0];

endmodule

// File: rtl/mantissa_mul_seq.sv
// Sequential shift-add mantissa multiplier: one partial product per clock,
// full 2*MANTISSA_LENGTH-bit product with start/busy/done handshake.
module mantissa_mul_seq
    import mantissa_mul_seq_pkg::*;
#(
    parameter int MANTISSA_LENGTH = mantissa_mul_seq_pkg::MANTISSA_LENGTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [MANTISSA_LENGTH-1:0]     operand_a,
    input  logic [MANTISSA_LENGTH-1:0]     operand_b,
    output logic                           busy,
    output logic                           done,
    output logic [2*MANTISSA_LENGTH-1:0]   product,
    output logic                           norm_shift
);

    localparam int ML = MANTISSA_LENGTH;
    localparam int CW = (ML > 1) ? $clog2(ML) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(ML - 1);

    mul_state_e     state;
    logic [ML-1:0]  mcand_r;
    logic [ML-1:0]  mplier_r;
    logic [ML-1:0]  acc_hi;
    logic [ML-1:0]  acc_lo;
    logic [CW-1:0]  count;
    logic [ML-1:0]  next_acc_hi;
    logic           shift_bit;
    logic           accept;

    assign accept = start && (state == ST_IDLE || state == ST_DONE);

    single_mul_step #(.MANTISSA_LENGTH(ML)) u_step (
        .acc_hi      (acc_hi),
        .mcand       (mcand_r),
        .mplier_lsb  (mplier_r[0]),
        .next_acc_hi (next_acc_hi),
        .shift_bit   (shift_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            product    <= '0;
            norm_shift <= 1'b0;
            mcand_r    <= '0;
            mplier_r   <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            count      <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                // DONE also accepts, giving zero-bubble back-to-back operation.
                mcand_r  <= operand_a;
                mplier_r <= operand_b;
                acc_hi   <= '0;
                acc_lo   <= '0;
                count    <= '0;
                state    <= ST_RUN;
                busy     <= 1'b1;
            end else begin
                case (state)
                    ST_RUN: begin
                        acc_hi   <= next_acc_hi;
                        acc_lo   <= {shift_bit, acc_lo[ML-1:1]};
                        mplier_r <= mplier_r >> 1;
                        count    <= count + CW'(1);
                        if (count == LAST_STEP) begin
                            state      <= ST_DONE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            product    <= {next_acc_hi, shift_bit, acc_lo[ML-1:1]};
                            norm_shift <= next_acc_hi[ML-1];
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
